mux4_rr_collector: RTL and testbench
====================================

Name: mux4_rr_collector

Overview:
- Collection side of the 1-to-4 demux path: gathers data from four source channels onto one registered output stream.
- Each source has its own valid/ready handshake. A round-robin arbiter picks one requesting channel per cycle.
- The output carries the data plus a 2-bit select tag naming the source channel, so a downstream 1-to-4 demux can route it back.
- Sits between four producers and one shared consumer.

Parameters:
- DATA_W, 8, width of each channel's data word.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Enable  input  1  when low, no new input is accepted; a held output word still drains.
- in_valid  input  4  per-channel request; bit i belongs to channel i.
- in_data  input  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  4  one-hot or zero; bit i high means channel i is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered word.
- out_sel  output  2  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is held 0 during any cycle with rst high.
  - Reset mid-transfer drops the held word; no input is accepted in that cycle.
- State: out_valid acts as a two-state FSM.
  - EMPTY to FULL on accept.
  - FULL to FULL on simultaneous drain and accept.
  - FULL to EMPTY on drain with no accept.
- load_en = !out_valid | out_ready.
- accept = Enable & load_en & |in_valid & !rst.
- Grant:
  - Search in_valid starting at rr_ptr, ascending, wrapping 3 to 0.
  - The first set bit wins; in_ready = onehot(winner) & accept.
  - in_ready depends combinationally on in_valid; sources must not make in_valid depend on in_ready.
- On accept:
  - out_data <= winner's data, out_sel <= winner index, out_valid <= 1.
  - rr_ptr <= (winner+1) mod 4.
- rr_ptr is unchanged when there is no accept.
- Latency and throughput: input accepted at edge N appears at out_valid after edge N; one word per cycle sustained with out_ready held high.
- Output stability: while out_valid & !out_ready, out_data and out_sel hold steady and in_ready=0.
- Enable low:
  - in_ready=0 and rr_ptr frozen.
  - A FULL register still drains to EMPTY on out_ready.
- Single requester: granted regardless of rr_ptr.
- No requester: in_ready=0; out_valid clears if drained.

Optional Feature:
- Macro: MUX4_RR_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, channel 0 highest and channel 3 lowest; rr_ptr is not implemented.
- All other timing and handshake behaviour is identical in both builds.

Decomposition:
- Shared package mux_pkg:
  - NUM_CH=4 and SEL_W=2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - Function onehot_to_idx.
- One natural sub-module: rr_arbiter4.
  - Inputs: req[3:0], ptr, advance.
  - Outputs: grant[3:0], grant_idx, next pointer.
  - The fixed-priority variant goes inside it under the macro.
- Top level holds the output register and handshake.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=4'b1111 → in_ready=0, out_valid=0, out_data=0, out_sel=0.
- Round robin: in_valid=4'b1111 held, out_ready=1, data 8'hA0..8'hA3.
  - MUX4_RR_EN defined → out_sel sequence 0,1,2,3,0 one per cycle with matching data.
  - MUX4_RR_EN undefined → out_sel stays 0.
- Backpressure: accept channel 2 (8'h5C), then out_ready=0 for 3 cycles → out_valid=1, out_data=8'h5C, out_sel=2 stable, in_ready=0; drains on the cycle out_ready=1.
- Wrap: rr_ptr=3 with in_valid=4'b0011 → channel 0 granted, rr_ptr becomes 1.
- Enable low: Enable=0, in_valid=4'b0100 → in_ready=0; an already-FULL register drains with out_ready=1 and out_valid drops to 0.
- Reset mid-operation: out_valid=1 and rst pulsed for 1 cycle → out_valid=0 next cycle; rr_ptr=0, so with in_valid=4'b1111 the next grant goes to channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 4-channel collector: channel count, select tag type,
// output-register state encoding and a one-hot to index helper.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic sel_t onehot_to_idx(input logic [NUM_CH-1:0] oh);
    sel_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = idx | sel_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way request arbiter. With MUX4_RR_EN defined it searches upward from ptr
// and wraps; otherwise it is fixed priority with channel 0 highest.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
`ifdef MUX4_RR_EN
  input  sel_t              ptr,
  input  logic              advance,
  output sel_t              next_ptr,
`endif
  output logic [NUM_CH-1:0] grant,
  output sel_t              grant_idx
);

`ifdef MUX4_RR_EN
  sel_t cand;
  logic found;

  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ptr + sel_t'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant    = found ? (NUM_CH'(1) << grant_idx) : '0;
    next_ptr = advance ? sel_t'(grant_idx + sel_t'(1)) : ptr;
  end
`else
  // Lowest set bit wins: isolate it, then encode.
  always_comb begin
    grant     = req & ~(req - NUM_CH'(1));
    grant_idx = onehot_to_idx(grant);
  end
`endif

endmodule

// File: rtl/mux4_rr_collector.sv
// Collects four valid/ready source channels into one registered output stream
// tagged with the source index. Define MUX4_RR_EN for round-robin arbitration.
module mux4_rr_collector
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Enable,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output sel_t                     out_sel,
  input  logic                     out_ready
);

  state_t            state;
  logic              load_en;
  logic              accept;
  logic [NUM_CH-1:0] grant;
  sel_t              grant_idx;

`ifdef MUX4_RR_EN
  sel_t rr_ptr;
  sel_t next_ptr;
`endif

  rr_arbiter4 u_arb (
    .req       (in_valid),
`ifdef MUX4_RR_EN
    .ptr       (rr_ptr),
    .advance   (accept),
    .next_ptr  (next_ptr),
`endif
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The register can take a new word when empty or when its word leaves this cycle.
  assign load_en   = (state == ST_EMPTY) || out_ready;
  assign accept    = Enable && load_en && (|in_valid) && !rst;
  assign in_ready  = grant & {NUM_CH{accept}};
  assign out_valid = (state == ST_FULL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (out_ready && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (accept) begin
        out_data <= in_data[grant_idx*DATA_W +: DATA_W];
        out_sel  <= grant_idx;
      end
    end
  end

`ifdef MUX4_RR_EN
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= next_ptr;
  end
`endif

endmodule

// File: tb/tb_mux4_rr_collector.sv
// Scoreboard bench for mux4_rr_collector: stimulus pushes expected words, a
// negedge monitor pops one per drained output. Expectations follow MUX4_RR_EN.
module tb_mux4_rr_collector;

  localparam int DATA_W = 8;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        Enable;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mux4_rr_collector #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Enable    (Enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [7:0] data);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
  endtask

  // A word leaves at the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_sel", 32'(out_sel), 32'(e.sel));
        check("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] w;

    // Reset with every channel requesting.
    rst = 1'b1; Enable = 1'b1; in_valid = 4'b1111;
    in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    check("rst_in_ready2", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'h0);

    // All four request continuously with out_ready high.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef MUX4_RR_EN
      w = 2'(i % 4);
`else
      w = 2'd0;
`endif
      #1;
      check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << w));
      push(w, 8'hA0 + 8'(w));
      step();
      check("rr_out_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 4'b0000;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h0);
    step();
    check("drained_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: channel 2 accepted, then consumer stalls for 3 cycles.
    in_valid = 4'b0100; in_data = 32'h005C0000; out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h4);
    push(2'd2, 8'h5C);
    step();
    in_data = 32'h00770000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_hold_data", 32'(out_data), 32'h5C);
      check("bp_hold_sel", 32'(out_sel), 32'h2);
      check("bp_hold_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    in_valid = 4'b0000; out_ready = 1'b1;
    step();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Wrap: pointer sits at 3 after granting channel 2; channels 0 and 1 request.
    in_valid = 4'b0011; in_data = 32'h00002211;
    #1;
    check("wrap_in_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'h11);
    step();
`ifdef MUX4_RR_EN
    w = 2'd1;
`else
    w = 2'd0;
`endif
    check("wrap_next_in_ready", 32'(in_ready), 32'(4'b0001 << w));
    push(w, (w == 2'd1) ? 8'h22 : 8'h11);
    step();
    in_valid = 4'b0000;
    step();
    check("wrap_drained", 32'(out_valid), 32'h0);

    // Enable low: a full register still drains, nothing new is accepted.
    in_valid = 4'b0100; in_data = 32'h00990000;
    #1;
    check("en_fill_in_ready", 32'(in_ready), 32'h4);
    push(2'd2, 8'h99);
    step();
    Enable = 1'b0;
    #1;
    check("en_low_in_ready", 32'(in_ready), 32'h0);
    step();
    check("en_low_drained", 32'(out_valid), 32'h0);
    check("en_low_in_ready2", 32'(in_ready), 32'h0);
    step();
    check("en_low_stays_empty", 32'(out_valid), 32'h0);

    // Reset mid-operation: the held word is dropped, pointer returns to 0.
    Enable = 1'b1; in_valid = 4'b0010; in_data = 32'h0000AB00; out_ready = 1'b0;
    step();
    check("mid_full", 32'(out_valid), 32'h1);
    rst = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2A1A0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_out_data", 32'(out_data), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'hA0);
    step();
    in_valid = 4'b0000;
    step();
    check("final_empty", 32'(out_valid), 32'h0);
    step();
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
